// File: rtl/tt_ldb_drain_pkg.sv
// Shared types and constants for the LDB drain engine.
// The beat tag struct is sized from the package depth constants. Depth
// overrides on the top must therefore be made here as well.
package tt_ldb_drain_pkg;

  localparam int LDB_DEPTH_DEF = 8;
  localparam int LQ_DEPTH_DEF  = 8;
  localparam int LDB_IW        = $clog2(LDB_DEPTH_DEF);
  localparam int LQ_IW         = $clog2(LQ_DEPTH_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_e;

  // Tag that travels with every beat from read issue to writeback.
  typedef struct packed {
    logic [LDB_IW-1:0] ldb_idx;
    logic [LQ_IW-1:0]  lqid;
    logic              last;
  } beat_tag_t;

  // Saturating 32-bit increment for the performance counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/tt_ldb_drain_ctrl_if.sv
// Writeback beat bus plus drain-complete sideband of the LDB drain engine.
//
// Handshake: a beat transfers in any cycle where o_wb_valid && i_wb_ready.
// Once o_wb_valid is high, it and the whole beat payload (data, ldb_idx,
// lqid, last) hold steady until that transfer. o_drain_complete_valid is high
// exactly in the transfer cycle and names the slot of the transferring beat.
interface tt_ldb_drain_ctrl_if
  import tt_ldb_drain_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int LDB_AW = LDB_IW,
  parameter int LQ_AW  = LQ_IW
);

  logic              o_wb_valid;
  logic              i_wb_ready;
  logic [DATA_W-1:0] o_wb_data;
  logic [LDB_AW-1:0] o_wb_ldb_idx;
  logic [LQ_AW-1:0]  o_wb_lqid;
  logic              o_wb_last;
  logic              o_drain_complete_valid;
  logic [LDB_AW-1:0] o_drain_complete_ldb_idx;

  // Drain engine side: produces beats and complete pulses.
  modport master (
    output o_wb_valid,
    input  i_wb_ready,
    output o_wb_data,
    output o_wb_ldb_idx,
    output o_wb_lqid,
    output o_wb_last,
    output o_drain_complete_valid,
    output o_drain_complete_ldb_idx
  );

  // Consumer side: accepts beats, observes complete pulses.
  modport slave (
    input  o_wb_valid,
    output i_wb_ready,
    input  o_wb_data,
    input  o_wb_ldb_idx,
    input  o_wb_lqid,
    input  o_wb_last,
    input  o_drain_complete_valid,
    input  o_drain_complete_ldb_idx
  );

endinterface

// File: rtl/tt_ldb_drain_skid.sv
// Two-entry FIFO holding landed read data plus its beat tag until the
// writeback consumer takes it. Head is presented straight from storage so
// the payload cannot change while the head waits. Push and pop in the same
// cycle on a full buffer is allowed: the pushed entry lands in the slot the
// departing head frees.
module tt_ldb_drain_skid
  import tt_ldb_drain_pkg::*;
#(
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  beat_tag_t         i_tag,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output beat_tag_t         o_tag,
  output logic [1:0]        o_occ
);

  logic [DATA_W-1:0] data_q [2];
  beat_tag_t         tag_q  [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        occ_q;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = i_pop && (occ_q != 2'd0);
  assign do_push = i_push && ((occ_q != 2'd2) || do_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (do_push) begin
        data_q[wr_ptr_q] <= i_data;
        tag_q[wr_ptr_q]  <= i_tag;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign o_valid = (occ_q != 2'd0);
  assign o_data  = data_q[rd_ptr_q];
  assign o_tag   = tag_q[rd_ptr_q];
  assign o_occ   = occ_q;

endmodule

// File: rtl/tt_ldb_drain_ctrl.sv
// LDB drain engine: accepts one drain request at a time, reads the LDB slots
// in order, forwards each slot as a writeback beat under backpressure and
// pulses drain-complete for every beat the consumer takes.
// Optional feature macro: TT_LDB_DRAIN_PERF_EN (drain and stall counters).
module tt_ldb_drain_ctrl
  import tt_ldb_drain_pkg::*;
#(
  parameter int DATA_W    = 512,
  parameter int LDB_DEPTH = LDB_DEPTH_DEF,
  parameter int LQ_DEPTH  = LQ_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_drain_req,
  input  logic [3:0]                   i_drain_count,
  input  logic [$clog2(LQ_DEPTH)-1:0]  i_drain_lqid_start,
  input  logic [$clog2(LDB_DEPTH)-1:0] i_drain_ldb_start,
  output logic                         o_draining,
  output logic                         o_ldb_rd_en,
  output logic [$clog2(LDB_DEPTH)-1:0] o_ldb_rd_idx,
  input  logic [DATA_W-1:0]            i_ldb_rd_data,
  tt_ldb_drain_ctrl_if.master          wb,
  output logic [31:0]                  o_perf_drains,
  output logic [31:0]                  o_perf_stall_cycles,
  output drain_state_e                 o_dbg_state
);

  localparam int LDB_AW = $clog2(LDB_DEPTH);
  localparam int LQ_AW  = $clog2(LQ_DEPTH);

  drain_state_e      state_q;
  logic              draining_q;
  logic [3:0]        remain_q;
  logic [LDB_AW-1:0] ldb_ptr_q;
  logic [LQ_AW-1:0]  lq_ptr_q;

  logic              rd_pending_q;
  beat_tag_t         rd_tag_q;

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  beat_tag_t         skid_tag;
  logic [1:0]        skid_occ;

  logic              accept;
  logic              pop;
  logic [1:0]        occ_after_pop;
  logic              issue;

  assign accept = (state_q == IDLE) && i_drain_req && !draining_q;
  assign pop    = skid_valid && wb.i_wb_ready;

  // A beat leaving this cycle frees its slot in time for a read issued now,
  // which is what lets the engine sustain one beat per cycle.
  assign occ_after_pop = skid_occ - {1'b0, pop};
  assign issue = (state_q == READ) &&
                 (({1'b0, occ_after_pop} + {2'b00, rd_pending_q}) < 3'd2);

  // Drain sequencing: request latch, read walk, flush wait, done gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      draining_q <= 1'b0;
      remain_q   <= 4'd0;
      ldb_ptr_q  <= '0;
      lq_ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            remain_q   <= i_drain_count;
            ldb_ptr_q  <= i_drain_ldb_start;
            lq_ptr_q   <= i_drain_lqid_start;
            draining_q <= 1'b1;
            state_q    <= (i_drain_count == 4'd0) ? DONE : READ;
          end
        end
        READ: begin
          if (issue) begin
            ldb_ptr_q <= ldb_ptr_q + LDB_AW'(1);
            lq_ptr_q  <= lq_ptr_q + LQ_AW'(1);
            remain_q  <= remain_q - 4'd1;
            if (remain_q == 4'd1) begin
              state_q <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (!rd_pending_q && (skid_occ == 2'd0)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          draining_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          draining_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  // Remember which slot each read belongs to until its data lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending_q <= 1'b0;
      rd_tag_q     <= '0;
    end else begin
      rd_pending_q <= issue;
      if (issue) begin
        rd_tag_q <= '{ldb_idx: ldb_ptr_q,
                      lqid:    lq_ptr_q,
                      last:    (remain_q == 4'd1)};
      end
    end
  end

  tt_ldb_drain_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_push  (rd_pending_q),
    .i_data  (i_ldb_rd_data),
    .i_tag   (rd_tag_q),
    .i_pop   (pop),
    .o_valid (skid_valid),
    .o_data  (skid_data),
    .o_tag   (skid_tag),
    .o_occ   (skid_occ)
  );

  assign o_draining   = draining_q;
  assign o_ldb_rd_en  = issue;
  assign o_ldb_rd_idx = ldb_ptr_q;
  assign o_dbg_state  = state_q;

  assign wb.o_wb_valid               = skid_valid;
  assign wb.o_wb_data                = skid_data;
  assign wb.o_wb_ldb_idx             = skid_tag.ldb_idx;
  assign wb.o_wb_lqid                = skid_tag.lqid;
  assign wb.o_wb_last                = skid_tag.last;
  assign wb.o_drain_complete_valid   = pop;
  assign wb.o_drain_complete_ldb_idx = skid_tag.ldb_idx;

`ifdef TT_LDB_DRAIN_PERF_EN
  logic [31:0] perf_drains_q;
  logic [31:0] perf_stall_q;

  // Saturating counts of accepted drains and backpressured beat cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_drains_q <= 32'd0;
      perf_stall_q  <= 32'd0;
    end else begin
      if (accept) begin
        perf_drains_q <= sat_inc32(perf_drains_q);
      end
      if (skid_valid && !wb.i_wb_ready) begin
        perf_stall_q <= sat_inc32(perf_stall_q);
      end
    end
  end

  assign o_perf_drains       = perf_drains_q;
  assign o_perf_stall_cycles = perf_stall_q;
`else
  assign o_perf_drains       = 32'd0;
  assign o_perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_tt_ldb_drain_ctrl.sv
// Directed bench for the LDB drain engine.
module tb_tt_ldb_drain_ctrl;
  import tt_ldb_drain_pkg::*;

  localparam int DATA_W = 512;

  logic              clk = 1'b0;
  logic              reset;
  logic              req;
  logic [3:0]        cnt;
  logic [2:0]        lq_start;
  logic [2:0]        ldb_start;
  logic              draining;
  logic              rd_en;
  logic [2:0]        rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic [31:0]       perf_d;
  logic [31:0]       perf_s;
  drain_state_e      dbg_state;
  logic [7:0]        salt;

  int vec_cnt = 0;
  int err_cnt = 0;

  tt_ldb_drain_ctrl_if #(.DATA_W(DATA_W), .LDB_AW(3), .LQ_AW(3)) wb_if ();

  tt_ldb_drain_ctrl #(
    .DATA_W    (DATA_W),
    .LDB_DEPTH (8),
    .LQ_DEPTH  (8)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_drain_req         (req),
    .i_drain_count       (cnt),
    .i_drain_lqid_start  (lq_start),
    .i_drain_ldb_start   (ldb_start),
    .o_draining          (draining),
    .o_ldb_rd_en         (rd_en),
    .o_ldb_rd_idx        (rd_idx),
    .i_ldb_rd_data       (rd_data),
    .wb                  (wb_if),
    .o_perf_drains       (perf_d),
    .o_perf_stall_cycles (perf_s),
    .o_dbg_state         (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DATA_W-1:0] data_of(input logic [2:0] idx, input logic [7:0] s);
    logic [31:0] w;
    w = {8'hD5, s, 13'h0, idx};
    return {16{w}};
  endfunction

  // LDB model: data for the strobed slot appears one cycle later.
  always @(posedge clk) begin
    if (rd_en) rd_data <= data_of(rd_idx, salt);
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = 1'b0;
    wb_if.i_wb_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_req(input logic [3:0] c, input logic [2:0] ldb, input logic [2:0] lq);
    @(negedge clk);
    req = 1'b1;
    cnt = c;
    ldb_start = ldb;
    lq_start = lq;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    req = 1'b0;
    wb_if.i_wb_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vec_cnt++; if (draining !== 1'b0) begin err_cnt++; $display("FAIL reset_draining got %b want 0", draining); end
    vec_cnt++; if (rd_en !== 1'b0) begin err_cnt++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
    vec_cnt++; if (wb_if.o_wb_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_wb_valid got %b want 0", wb_if.o_wb_valid); end
    vec_cnt++; if (wb_if.o_drain_complete_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_complete got %b want 0", wb_if.o_drain_complete_valid); end
    vec_cnt++; if (wb_if.o_wb_data !== '0) begin err_cnt++; $display("FAIL reset_wb_data got %h want 0", wb_if.o_wb_data[31:0]); end
    vec_cnt++; if (perf_d !== 32'd0 || perf_s !== 32'd0) begin err_cnt++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_d, perf_s); end
    vec_cnt++; if (dbg_state !== IDLE) begin err_cnt++; $display("FAIL reset_state got %0d want %0d", int'(dbg_state), int'(IDLE)); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // count=3, ldb 6, lq 5, no backpressure: full cycle-exact timeline.
  task automatic test_basic();
    logic [2:0]   e_idx;
    logic [2:0]   e_lq;
    drain_state_e e_st;
    salt = 8'h11;
    wb_if.i_wb_ready = 1'b1;
    start_req(4'd3, 3'd6, 3'd5);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      req = 1'b0;
      #1;
      e_st = (c <= 3) ? READ : (c <= 6) ? FLUSH : (c == 7) ? DONE : IDLE;
      vec_cnt++; if (dbg_state !== e_st) begin err_cnt++; $display("FAIL basic_state c%0d got %0d want %0d", c, int'(dbg_state), int'(e_st)); end
      vec_cnt++; if (draining !== (c <= 7)) begin err_cnt++; $display("FAIL basic_draining c%0d got %b want %b", c, draining, (c <= 7)); end
      vec_cnt++; if (rd_en !== (c <= 3)) begin err_cnt++; $display("FAIL basic_rd_en c%0d got %b want %b", c, rd_en, (c <= 3)); end
      if (c <= 3) begin
        e_idx = 3'((6 + c - 1) % 8);
        vec_cnt++; if (rd_idx !== e_idx) begin err_cnt++; $display("FAIL basic_rd_idx c%0d got %0d want %0d", c, rd_idx, e_idx); end
      end
      vec_cnt++; if (wb_if.o_wb_valid !== (c >= 3 && c <= 5)) begin err_cnt++; $display("FAIL basic_wb_valid c%0d got %b want %b", c, wb_if.o_wb_valid, (c >= 3 && c <= 5)); end
      vec_cnt++; if (wb_if.o_drain_complete_valid !== (c >= 3 && c <= 5)) begin err_cnt++; $display("FAIL basic_complete c%0d got %b want %b", c, wb_if.o_drain_complete_valid, (c >= 3 && c <= 5)); end
      if (c >= 3 && c <= 5) begin
        e_idx = 3'((6 + c - 3) % 8);
        e_lq  = 3'((5 + c - 3) % 8);
        vec_cnt++; if (wb_if.o_wb_ldb_idx !== e_idx) begin err_cnt++; $display("FAIL basic_wb_idx c%0d got %0d want %0d", c, wb_if.o_wb_ldb_idx, e_idx); end
        vec_cnt++; if (wb_if.o_wb_lqid !== e_lq) begin err_cnt++; $display("FAIL basic_wb_lqid c%0d got %0d want %0d", c, wb_if.o_wb_lqid, e_lq); end
        vec_cnt++; if (wb_if.o_wb_last !== (c == 5)) begin err_cnt++; $display("FAIL basic_wb_last c%0d got %b want %b", c, wb_if.o_wb_last, (c == 5)); end
        vec_cnt++; if (wb_if.o_wb_data !== data_of(e_idx, salt)) begin err_cnt++; $display("FAIL basic_wb_data c%0d got %h want %h", c, wb_if.o_wb_data[31:0], data_of(e_idx, salt) & 32'hFFFF_FFFF); end
        vec_cnt++; if (wb_if.o_drain_complete_ldb_idx !== e_idx) begin err_cnt++; $display("FAIL basic_cpl_idx c%0d got %0d want %0d", c, wb_if.o_drain_complete_ldb_idx, e_idx); end
      end
    end
  endtask

  // count=8 from slot 2, ready toggling: order, stability, buffering bound.
  task automatic test_backpressure();
    logic [2:0]        exp_q[$];
    logic [2:0]        exp_lq_q[$];
    logic [2:0]        exp_rd_q[$];
    logic              prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic [2:0]        prev_idx;
    logic [2:0]        prev_lq;
    logic              prev_last;
    int done, compl, iss_now, iss_m1, iss_m2, buffered;
    logic [2:0] e;
    salt = 8'h22;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(3'((2 + k) % 8));
      exp_rd_q.push_back(3'((2 + k) % 8));
      exp_lq_q.push_back(3'((3 + k) % 8));
    end
    done = 0; compl = 0; iss_now = 0; iss_m1 = 0; iss_m2 = 0;
    prev_stall = 1'b0; prev_data = '0; prev_idx = '0; prev_lq = '0; prev_last = 1'b0;
    wb_if.i_wb_ready = 1'b1;
    start_req(4'd8, 3'd2, 3'd3);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      req = 1'b0;
      wb_if.i_wb_ready = c[0];
      #1;
      buffered = iss_m2 - done;
      vec_cnt++; if (buffered > 2) begin err_cnt++; $display("FAIL bp_buffered c%0d got %0d want <=2", c, buffered); end
      vec_cnt++; if (wb_if.o_wb_valid !== (buffered != 0)) begin err_cnt++; $display("FAIL bp_valid c%0d got %b want %b", c, wb_if.o_wb_valid, (buffered != 0)); end
      if (prev_stall) begin
        vec_cnt++;
        if (wb_if.o_wb_valid !== 1'b1 || wb_if.o_wb_data !== prev_data || wb_if.o_wb_ldb_idx !== prev_idx ||
            wb_if.o_wb_lqid !== prev_lq || wb_if.o_wb_last !== prev_last) begin
          err_cnt++; $display("FAIL bp_hold c%0d got idx %0d want %0d (payload changed during stall)", c, wb_if.o_wb_ldb_idx, prev_idx);
        end
      end
      if (rd_en === 1'b1) begin
        e = (exp_rd_q.size() != 0) ? exp_rd_q.pop_front() : 3'bxxx;
        vec_cnt++; if (rd_idx !== e) begin err_cnt++; $display("FAIL bp_rd_idx c%0d got %0d want %0d", c, rd_idx, e); end
        iss_now++;
      end
      vec_cnt++; if (wb_if.o_drain_complete_valid !== (wb_if.o_wb_valid && wb_if.i_wb_ready)) begin err_cnt++; $display("FAIL bp_complete c%0d got %b want %b", c, wb_if.o_drain_complete_valid, (wb_if.o_wb_valid && wb_if.i_wb_ready)); end
      if (wb_if.o_drain_complete_valid === 1'b1) compl++;
      if (wb_if.o_wb_valid === 1'b1 && wb_if.i_wb_ready === 1'b1) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
        vec_cnt++; if (wb_if.o_wb_ldb_idx !== e) begin err_cnt++; $display("FAIL bp_wb_idx beat%0d got %0d want %0d", done, wb_if.o_wb_ldb_idx, e); end
        vec_cnt++; if (wb_if.o_drain_complete_ldb_idx !== e) begin err_cnt++; $display("FAIL bp_cpl_idx beat%0d got %0d want %0d", done, wb_if.o_drain_complete_ldb_idx, e); end
        vec_cnt++; if (wb_if.o_wb_data !== data_of(e, salt)) begin err_cnt++; $display("FAIL bp_wb_data beat%0d got %h want %h", done, wb_if.o_wb_data[31:0], data_of(e, salt) & 32'hFFFF_FFFF); end
        e = (exp_lq_q.size() != 0) ? exp_lq_q.pop_front() : 3'bxxx;
        vec_cnt++; if (wb_if.o_wb_lqid !== e) begin err_cnt++; $display("FAIL bp_wb_lqid beat%0d got %0d want %0d", done, wb_if.o_wb_lqid, e); end
        vec_cnt++; if (wb_if.o_wb_last !== (done == 7)) begin err_cnt++; $display("FAIL bp_wb_last beat%0d got %b want %b", done, wb_if.o_wb_last, (done == 7)); end
        done++;
      end
      prev_stall = (wb_if.o_wb_valid === 1'b1) && (wb_if.i_wb_ready === 1'b0);
      prev_data = wb_if.o_wb_data; prev_idx = wb_if.o_wb_ldb_idx;
      prev_lq = wb_if.o_wb_lqid; prev_last = wb_if.o_wb_last;
      iss_m2 = iss_m1; iss_m1 = iss_now;
      if (done >= 8 && draining === 1'b0) break;
    end
    wb_if.i_wb_ready = 1'b1;
    vec_cnt++; if (done != 8) begin err_cnt++; $display("FAIL bp_beats got %0d want 8", done); end
    vec_cnt++; if (compl != 8) begin err_cnt++; $display("FAIL bp_completes got %0d want 8", compl); end
    vec_cnt++; if (iss_now != 8) begin err_cnt++; $display("FAIL bp_reads got %0d want 8", iss_now); end
    vec_cnt++; if (draining !== 1'b0) begin err_cnt++; $display("FAIL bp_idle got draining %b want 0", draining); end
  endtask

  // count=0: no traffic, o_draining high for exactly one cycle.
  task automatic test_zero();
    int hi;
    salt = 8'h33;
    hi = 0;
    wb_if.i_wb_ready = 1'b1;
    start_req(4'd0, 3'd4, 3'd4);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      req = 1'b0;
      #1;
      if (draining === 1'b1) hi++;
      vec_cnt++; if (draining !== (c == 1)) begin err_cnt++; $display("FAIL zero_draining c%0d got %b want %b", c, draining, (c == 1)); end
      vec_cnt++; if (rd_en !== 1'b0 || wb_if.o_wb_valid !== 1'b0 || wb_if.o_drain_complete_valid !== 1'b0) begin
        err_cnt++; $display("FAIL zero_traffic c%0d got rd %b wb %b cpl %b want 0 0 0", c, rd_en, wb_if.o_wb_valid, wb_if.o_drain_complete_valid);
      end
    end
    vec_cnt++; if (hi != 1) begin err_cnt++; $display("FAIL zero_busy_cycles got %0d want 1", hi); end
  endtask

  // Request held high: second acceptance only after the low cycle; request
  // fields changing while busy are not latched.
  task automatic test_back_to_back();
    logic e_dr;
    logic e_rd;
    logic e_wb;
    salt = 8'h44;
    wb_if.i_wb_ready = 1'b1;
    start_req(4'd1, 3'd3, 3'd1);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 5) begin cnt = 4'd7; ldb_start = 3'd0; lq_start = 3'd6; end
      if (c == 6) begin cnt = 4'd1; ldb_start = 3'd3; lq_start = 3'd1; end
      if (c >= 8) req = 1'b0;
      #1;
      e_dr = (c <= 5) || (c >= 7 && c <= 11);
      e_rd = (c == 1) || (c == 7);
      e_wb = (c == 3) || (c == 9);
      vec_cnt++; if (draining !== e_dr) begin err_cnt++; $display("FAIL b2b_draining c%0d got %b want %b", c, draining, e_dr); end
      vec_cnt++; if (rd_en !== e_rd) begin err_cnt++; $display("FAIL b2b_rd_en c%0d got %b want %b", c, rd_en, e_rd); end
      vec_cnt++; if (wb_if.o_wb_valid !== e_wb) begin err_cnt++; $display("FAIL b2b_wb_valid c%0d got %b want %b", c, wb_if.o_wb_valid, e_wb); end
      if (e_rd) begin
        vec_cnt++; if (rd_idx !== 3'd3) begin err_cnt++; $display("FAIL b2b_rd_idx c%0d got %0d want 3", c, rd_idx); end
      end
      if (e_wb) begin
        vec_cnt++; if (wb_if.o_wb_lqid !== 3'd1 || wb_if.o_wb_last !== 1'b1) begin
          err_cnt++; $display("FAIL b2b_beat c%0d got lqid %0d last %b want 1 1", c, wb_if.o_wb_lqid, wb_if.o_wb_last);
        end
      end
    end
  endtask

  // Reset during the second beat of a count=4 drain, then a fresh drain.
  task automatic test_reset_mid();
    int compl;
    salt = 8'h55;
    compl = 0;
    wb_if.i_wb_ready = 1'b1;
    start_req(4'd4, 3'd0, 3'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      req = 1'b0;
      if (c == 4) reset = 1'b1;
      #1;
      if (wb_if.o_drain_complete_valid === 1'b1) compl++;
    end
    vec_cnt++; if (compl != 2) begin err_cnt++; $display("FAIL rst_mid_pre_completes got %0d want 2", compl); end
    @(negedge clk);
    #1;
    vec_cnt++; if (draining !== 1'b0 || rd_en !== 1'b0 || rd_idx !== 3'd0) begin
      err_cnt++; $display("FAIL rst_mid_ctrl got draining %b rd %b idx %0d want 0 0 0", draining, rd_en, rd_idx);
    end
    vec_cnt++; if (wb_if.o_wb_valid !== 1'b0 || wb_if.o_wb_data !== '0 || wb_if.o_wb_last !== 1'b0 ||
                   wb_if.o_wb_ldb_idx !== 3'd0 || wb_if.o_wb_lqid !== 3'd0) begin
      err_cnt++; $display("FAIL rst_mid_wb got valid %b idx %0d lqid %0d want all 0", wb_if.o_wb_valid, wb_if.o_wb_ldb_idx, wb_if.o_wb_lqid);
    end
    vec_cnt++; if (wb_if.o_drain_complete_valid !== 1'b0 || wb_if.o_drain_complete_ldb_idx !== 3'd0) begin
      err_cnt++; $display("FAIL rst_mid_cpl got %b idx %0d want 0 0", wb_if.o_drain_complete_valid, wb_if.o_drain_complete_ldb_idx);
    end
    @(negedge clk);
    reset = 1'b0;
    compl = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (wb_if.o_drain_complete_valid === 1'b1 || wb_if.o_wb_valid === 1'b1) compl++;
    end
    vec_cnt++; if (compl != 0) begin err_cnt++; $display("FAIL rst_mid_post_traffic got %0d beats want 0", compl); end
    salt = 8'h56;
    start_req(4'd2, 3'd5, 3'd2);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      req = 1'b0;
      #1;
      vec_cnt++; if (wb_if.o_wb_valid !== (c == 3 || c == 4)) begin err_cnt++; $display("FAIL rst_new_valid c%0d got %b want %b", c, wb_if.o_wb_valid, (c == 3 || c == 4)); end
      if (c == 3 || c == 4) begin
        vec_cnt++;
        if (wb_if.o_wb_ldb_idx !== 3'(c + 2) || wb_if.o_wb_lqid !== 3'(c - 1) || wb_if.o_wb_last !== (c == 4) ||
            wb_if.o_wb_data !== data_of(3'(c + 2), salt)) begin
          err_cnt++; $display("FAIL rst_new_beat c%0d got idx %0d lqid %0d last %b want %0d %0d %b", c,
                              wb_if.o_wb_ldb_idx, wb_if.o_wb_lqid, wb_if.o_wb_last, c + 2, c - 1, (c == 4));
        end
      end
    end
  endtask

  // Two drains with 3 + 2 stall cycles; counters only exist with the macro.
  task automatic test_perf();
    int stalls;
    int k;
    logic [31:0] e_d;
    logic [31:0] e_s;
    do_reset();
    salt = 8'h66;
    for (int d = 0; d < 2; d++) begin
      k = (d == 0) ? 3 : 2;
      stalls = 0;
      if (d == 0) start_req(4'd2, 3'd0, 3'd0);
      else        start_req(4'd1, 3'd4, 3'd4);
      wb_if.i_wb_ready = 1'b0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        req = 1'b0;
        wb_if.i_wb_ready = (stalls >= k);
        #1;
        if (wb_if.o_wb_valid === 1'b1 && wb_if.i_wb_ready === 1'b0) stalls++;
        if (c > 1 && draining === 1'b0) break;
      end
      vec_cnt++; if (draining !== 1'b0) begin err_cnt++; $display("FAIL perf_drain%0d_end got draining %b want 0", d, draining); end
    end
    wb_if.i_wb_ready = 1'b1;
`ifdef TT_LDB_DRAIN_PERF_EN
    e_d = 32'd2;
    e_s = 32'd5;
`else
    e_d = 32'd0;
    e_s = 32'd0;
`endif
    @(negedge clk);
    #1;
    vec_cnt++; if (perf_d !== e_d) begin err_cnt++; $display("FAIL perf_drains got %0d want %0d", perf_d, e_d); end
    vec_cnt++; if (perf_s !== e_s) begin err_cnt++; $display("FAIL perf_stalls got %0d want %0d", perf_s, e_s); end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    reset = 1'b1;
    req = 1'b0;
    cnt = 4'd0;
    lq_start = 3'd0;
    ldb_start = 3'd0;
    rd_data = '0;
    salt = 8'h00;
    wb_if.i_wb_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    test_perf();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
